// File: rtl/module_mem_pkg.sv
// Shared types and default widths for the unified memory-port arbiter.
package module_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_IF,
        ST_REQ_DM,
        ST_WAIT_IF,
        ST_WAIT_DM,
        ST_DROP
    } mem_arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } mem_owner_t;

endpackage

// File: rtl/module_flopenr.sv
// Enabled flop with synchronous active-high reset.
module module_flopenr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/module_mem_arbiter.sv
// Shares one req/gnt/rvalid memory port between fetch and the M stage,
// one transaction in flight, dropping responses for killed fetches.
module module_mem_arbiter
    import module_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_kill_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_valid_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_fetch_o,
    output logic              stall_mem_o
);

    localparam int unsigned CAP_W = ADDR_W + DATA_W + 1;

    mem_arb_state_t state_q, state_d;
    mem_owner_t     last_q, last_d;
    logic           drop_q, drop_d;

    logic             if_elig, pick_dm, pick_if;
    logic             cap_en;
    logic [CAP_W-1:0] cap_d, cap_q;

    // Data normally wins; fetch wins a tie if data owned the previous transfer.
    assign if_elig = if_req_i & ~if_kill_i;
    assign pick_dm = dm_req_i & ~(if_elig & (last_q == OWN_DM));
    assign pick_if = if_elig & ~pick_dm;

    assign cap_d = pick_dm ? {dm_addr_i, dm_we_i, dm_wdata_i}
                           : {if_addr_i, 1'b0, {DATA_W{1'b0}}};

    module_flopenr #(
        .WIDTH(CAP_W)
    ) u_cap (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (cap_en),
        .d_i   (cap_d),
        .q_o   (cap_q)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            last_q  <= OWN_IF;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        drop_d      = drop_q;
        cap_en      = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if_valid_o  = 1'b0;
        dm_valid_o  = 1'b0;

        if (!rst_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pick_dm || pick_if) begin
                        mem_req_o = 1'b1;
                        {mem_addr_o, mem_we_o, mem_wdata_o} = cap_d;
                        cap_en = ~mem_gnt_i;
                        drop_d = 1'b0;
                        if (pick_dm) begin
                            state_d = mem_gnt_i ? ST_WAIT_DM : ST_REQ_DM;
                        end else begin
                            state_d = mem_gnt_i ? ST_WAIT_IF : ST_REQ_IF;
                        end
                    end
                end
                ST_REQ_IF: begin
                    mem_req_o = 1'b1;
                    {mem_addr_o, mem_we_o, mem_wdata_o} = cap_q;
                    if (if_kill_i) begin
                        drop_d = 1'b1;
                    end
                    if (mem_gnt_i) begin
                        state_d = (drop_q || if_kill_i) ? ST_DROP : ST_WAIT_IF;
                        drop_d  = 1'b0;
                    end
                end
                ST_REQ_DM: begin
                    mem_req_o = 1'b1;
                    {mem_addr_o, mem_we_o, mem_wdata_o} = cap_q;
                    if (mem_gnt_i) begin
                        state_d = ST_WAIT_DM;
                    end
                end
                ST_WAIT_IF: begin
                    if (mem_rvalid_i) begin
                        state_d = ST_IDLE;
                        if (!if_kill_i) begin
                            if_valid_o = 1'b1;
                            last_d     = OWN_IF;
                        end
                    end else if (if_kill_i) begin
                        state_d = ST_DROP;
                    end
                end
                ST_WAIT_DM: begin
                    if (mem_rvalid_i) begin
                        dm_valid_o = 1'b1;
                        last_d     = OWN_DM;
                        state_d    = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (mem_rvalid_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign if_rdata_o    = if_valid_o ? mem_rdata_i : '0;
    assign dm_rdata_o    = dm_valid_o ? mem_rdata_i : '0;
    assign stall_fetch_o = if_req_i & ~if_valid_o;
    assign stall_mem_o   = dm_req_i & ~dm_valid_o;

endmodule

// File: tb/tb_module_mem_arbiter.sv
// Directed scoreboard bench for module_mem_arbiter.
module tb_module_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        if_req_i, if_kill_i, dm_req_i, dm_we_i;
    logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i;
    logic [31:0] if_rdata_o, dm_rdata_o;
    logic        if_valid_o, dm_valid_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        stall_fetch_o, stall_mem_o;

    int checks = 0;
    int errors = 0;

    logic [64:0] iss_q[$];
    logic [31:0] if_q[$];
    logic [31:0] dm_q[$];

    always #5 clk = ~clk;

    module_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_kill_i    (if_kill_i),
        .if_rdata_o   (if_rdata_o),
        .if_valid_o   (if_valid_o),
        .dm_req_i     (dm_req_i),
        .dm_we_i      (dm_we_i),
        .dm_addr_i    (dm_addr_i),
        .dm_wdata_i   (dm_wdata_i),
        .dm_rdata_o   (dm_rdata_o),
        .dm_valid_o   (dm_valid_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .stall_fetch_o(stall_fetch_o),
        .stall_mem_o  (stall_mem_o)
    );

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Monitor: pops expectations whenever the DUT issues or completes.
    always @(negedge clk) begin
        logic [64:0] e;
        if (mem_req_o && mem_gnt_i) begin
            if (iss_q.size() == 0) begin
                chk("unexpected_issue", {mem_we_o, mem_addr_o, mem_wdata_o}, 65'h0);
                if ({mem_we_o, mem_addr_o, mem_wdata_o} == 65'h0) begin
                    errors++;
                    $display("FAIL unexpected_issue: got issue expected none");
                end
            end else begin
                e = iss_q.pop_front();
                chk("issue_we_addr", {32'h0, mem_we_o, mem_addr_o}, {32'h0, e[64:32]});
                if (e[64]) chk("issue_wdata", {33'h0, mem_wdata_o}, {33'h0, e[31:0]});
            end
        end
        if (if_valid_o) begin
            if (if_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_if_valid: got rdata %0h expected no valid", if_rdata_o);
            end else begin
                chk("if_rdata", {33'h0, if_rdata_o}, {33'h0, if_q.pop_front()});
            end
        end
        if (dm_valid_o) begin
            if (dm_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_dm_valid: got rdata %0h expected no valid", dm_rdata_o);
            end else begin
                chk("dm_rdata", {33'h0, dm_rdata_o}, {33'h0, dm_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; if_req_i = 1'b1; if_addr_i = 32'h100; if_kill_i = 1'b0;
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        @(posedge clk); smp();
        chk("rst_mem_req", {64'h0, mem_req_o}, 65'h0);
        chk("rst_mem_bus", {mem_we_o, mem_addr_o, mem_wdata_o}, 65'h0);
        chk("rst_valids", {63'h0, if_valid_o, dm_valid_o}, 65'h0);
        chk("rst_rdata", {1'b0, if_rdata_o, dm_rdata_o}, 65'h0);
        chk("rst_stall_fetch", {64'h0, stall_fetch_o}, 65'h1);
        nxt(); rst_i = 1'b0; if_req_i = 1'b0; mem_gnt_i = 1'b0;

        // Fetch only, minimum latency
        nxt(); if_req_i = 1'b1; if_addr_i = 32'h100; mem_gnt_i = 1'b1;
        iss_q.push_back({1'b0, 32'h100, 32'h0});
        smp(); chk("t1_stall_issue", {64'h0, stall_fetch_o}, 65'h1);
        nxt(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00500093;
        if_q.push_back(32'h00500093);
        smp(); chk("t1_stall_resp", {64'h0, stall_fetch_o}, 65'h0);
        nxt(); if_req_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        smp(); chk("t1_single_pulse", {64'h0, if_valid_o}, 65'h0);

        // Contention after reset: store first, then fetch, then the next load
        nxt(); rst_i = 1'b1;
        nxt(); rst_i = 1'b0;
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h2000; dm_wdata_i = 32'hDEADBEEF;
        if_req_i = 1'b1; if_addr_i = 32'h104; mem_gnt_i = 1'b1;
        iss_q.push_back({1'b1, 32'h2000, 32'hDEADBEEF});
        smp(); chk("t2_we", {64'h0, mem_we_o}, 65'h1);
        chk("t2_stalls", {63'h0, stall_fetch_o, stall_mem_o}, 65'h3);
        nxt(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0;
        dm_q.push_back(32'h0);
        smp(); chk("t2_stalls_ack", {63'h0, stall_fetch_o, stall_mem_o}, 65'h2);
        nxt(); mem_rvalid_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = 32'h2004; dm_wdata_i = '0;
        mem_gnt_i = 1'b1;
        iss_q.push_back({1'b0, 32'h104, 32'h0});
        smp(); chk("t2_fetch_wins", {1'b0, mem_we_o, mem_addr_o, 31'h0}, {1'b0, 1'b0, 32'h104, 31'h0});
        chk("t2_stalls_f", {63'h0, stall_fetch_o, stall_mem_o}, 65'h3);
        nxt(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h12345678;
        if_q.push_back(32'h12345678);
        nxt(); if_req_i = 1'b0; mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1;
        iss_q.push_back({1'b0, 32'h2004, 32'h0});
        nxt(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
        dm_q.push_back(32'hCAFEF00D);
        nxt(); dm_req_i = 1'b0; mem_rvalid_i = 1'b0;

        // Grant backpressure holds captured address
        nxt(); if_req_i = 1'b1; if_addr_i = 32'h108; mem_gnt_i = 1'b0;
        smp(); chk("t3_addr0", {32'h0, mem_req_o, mem_addr_o}, {32'h0, 1'b1, 32'h108});
        nxt(); if_addr_i = 32'h200;
        smp(); chk("t3_addr1", {32'h0, mem_req_o, mem_addr_o}, {32'h0, 1'b1, 32'h108});
        nxt();
        smp(); chk("t3_addr2", {32'h0, mem_req_o, mem_addr_o}, {32'h0, 1'b1, 32'h108});
        nxt(); mem_gnt_i = 1'b1;
        iss_q.push_back({1'b0, 32'h108, 32'h0});
        nxt(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hAAAA0001; if_req_i = 1'b0;
        if_q.push_back(32'hAAAA0001);
        nxt(); mem_rvalid_i = 1'b0;

        // Kill in WAIT_IF, response dropped, redirect issues after DROP
        nxt(); if_req_i = 1'b1; if_addr_i = 32'h10C; mem_gnt_i = 1'b1;
        iss_q.push_back({1'b0, 32'h10C, 32'h0});
        nxt(); mem_gnt_i = 1'b0; if_kill_i = 1'b1; if_addr_i = 32'h300;
        smp(); chk("t4_no_req_kill", {64'h0, mem_req_o}, 65'h0);
        nxt(); if_kill_i = 1'b0; mem_gnt_i = 1'b1;
        smp(); chk("t4_no_req_drop", {64'h0, mem_req_o}, 65'h0);
        nxt(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
        smp(); chk("t4_dropped", {63'h0, if_valid_o, mem_req_o}, 65'h0);
        nxt(); mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1;
        iss_q.push_back({1'b0, 32'h300, 32'h0});
        smp(); chk("t4_redirect_req", {64'h0, mem_req_o}, 65'h1);
        nxt(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h00000013; if_req_i = 1'b0;
        if_q.push_back(32'h00000013);
        nxt(); mem_rvalid_i = 1'b0;

        // Kill in the same cycle as rvalid
        nxt(); if_req_i = 1'b1; if_addr_i = 32'h400; mem_gnt_i = 1'b1;
        iss_q.push_back({1'b0, 32'h400, 32'h0});
        nxt(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77; if_kill_i = 1'b1;
        if_addr_i = 32'h500;
        smp(); chk("t5_kill_rvalid", {64'h0, if_valid_o}, 65'h0);
        nxt(); if_kill_i = 1'b0; mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1;
        iss_q.push_back({1'b0, 32'h500, 32'h0});
        smp(); chk("t5_idle_issue", {32'h0, mem_req_o, mem_addr_o}, {32'h0, 1'b1, 32'h500});
        nxt(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11; if_req_i = 1'b0;
        if_q.push_back(32'h11);
        nxt(); mem_rvalid_i = 1'b0;

        // Reset in WAIT_DM; stray rvalid in IDLE ignored
        nxt(); dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h3000; mem_gnt_i = 1'b1;
        iss_q.push_back({1'b0, 32'h3000, 32'h0});
        nxt(); mem_gnt_i = 1'b0; rst_i = 1'b1; dm_req_i = 1'b0;
        smp(); chk("t6_rst_outs", {63'h0, mem_req_o, dm_valid_o}, 65'h0);
        nxt(); rst_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF;
        smp(); chk("t6_stray_rvalid", {31'h0, mem_req_o, dm_valid_o, dm_rdata_o}, 65'h0);
        nxt(); mem_rvalid_i = 1'b0; dm_req_i = 1'b1; dm_addr_i = 32'h3004; mem_gnt_i = 1'b1;
        iss_q.push_back({1'b0, 32'h3004, 32'h0});
        smp(); chk("t6_idle_issue", {64'h0, mem_req_o}, 65'h1);
        nxt(); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5A5A5A5A;
        dm_q.push_back(32'h5A5A5A5A);
        nxt(); mem_rvalid_i = 1'b0; dm_req_i = 1'b0;

        smp();
        chk("iss_q_empty", 65'(iss_q.size()), 65'h0);
        chk("if_q_empty", 65'(if_q.size()), 65'h0);
        chk("dm_q_empty", 65'(dm_q.size()), 65'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
